// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the conv-layer instruction sequencer: inst word
// bit positions, the idle instruction and the FSM state encoding.
package core_sequencer_pkg;

   localparam int INST_W   = 34;
   localparam int FIELD_AW = 11;

   localparam int BIT_ACC      = 33;
   localparam int BIT_CEN_P    = 32;
   localparam int BIT_WEN_P    = 31;
   localparam int A_P_LSB      = 20;
   localparam int BIT_CEN_X    = 19;
   localparam int BIT_WEN_X    = 18;
   localparam int A_X_LSB      = 7;
   localparam int BIT_OFIFO_RD = 6;
   localparam int BIT_IFIFO_WR = 5;
   localparam int BIT_IFIFO_RD = 4;
   localparam int BIT_L0_RD    = 3;
   localparam int BIT_L0_WR    = 2;
   localparam int BIT_EXEC     = 1;
   localparam int BIT_LOAD     = 0;

   // Both SRAMs deselected (CEN/WEN high, active-low), every strobe low.
   localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_FILL,
      S_W_LOAD,
      S_W_DRAIN,
      S_A_FILL,
      S_EXEC,
      S_O_DRAIN,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Control/status bundle between the layer controller (master) and the
// instruction sequencer (slave).
//
// Handshake: start is a one-cycle request, accepted only on a cycle where the
// sequencer is idle (busy=0); the config fields are sampled on that same
// cycle. There is no ready signal: a start seen while busy is dropped.
// ofifo_valid is a level from core meaning "a complete output row can be
// popped"; the sequencer answers with ofifo_rd inside inst.
interface core_sequencer_if
   import core_sequencer_pkg::*;
#(
   parameter int addr_w = 11,
   parameter int cnt_w  = 11
);
   logic              start;
   logic [3:0]        len_kij;
   logic [cnt_w-1:0]  len_nij;
   logic [addr_w-1:0] w_base;
   logic [addr_w-1:0] x_base;
   logic [addr_w-1:0] p_base;
   logic              ofifo_valid;
   logic [33:0]       inst;
   logic              busy;
   logic              done;
   logic [3:0]        kij_idx;
   seq_state_t        state_dbg;

   modport master (
      output start, len_kij, len_nij, w_base, x_base, p_base, ofifo_valid,
      input  inst, busy, done, kij_idx, state_dbg
   );

   modport slave (
      input  start, len_kij, len_nij, w_base, x_base, p_base, ofifo_valid,
      output inst, busy, done, kij_idx, state_dbg
   );
endinterface

// File: rtl/core_sequencer_seq_counter.sv
// Up-counter with synchronous load, count enable and a terminal-count flag.
// Used for the per-phase cycle counter and the ofifo read/pmem write counters.
module seq_counter #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         tc
);

   // Load has priority over counting.
   always_ff @(posedge clk) begin
      if (reset)     count <= '0;
      else if (load) count <= load_val;
      else if (en)   count <= count + 1'b1;
   end

   assign tc = (count == term);

endmodule

// File: rtl/core_sequencer.sv
// Per-cycle inst generator for one conv layer. For every kernel position it
// fills L0 with weights and loads the PE array, lets the weights settle,
// fills L0 with activations and executes, then drains ofifo into pmem.
// inst is registered: it reflects the FSM state of the previous cycle.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int addr_w = 11,
   parameter int cnt_w  = 11
) (
   input logic             clk,
   input logic             reset,
   core_sequencer_if.slave bus
);

   seq_state_t state, state_next;

   logic [3:0]        len_kij_q, kij_q;
   logic [cnt_w-1:0]  len_nij_q;
   logic [addr_w-1:0] w_base_q, x_base_q, p_base_q;
   logic [addr_w-1:0] w_off_q, p_off_q;   // per-kij offsets, kept as running sums
   logic              wr_pend_q;          // an ofifo row was popped last cycle
   logic [33:0]       inst_q, inst_d;
   logic              busy_q, busy_d, done_q, done_d;

   logic [cnt_w-1:0]  ph_cnt, rd_cnt, wr_cnt, ph_term;
   logic              ph_tc, rd_all, wr_tc;
   logic              start_ok, start_run, rd_issue, wr_last, more_kij;

   assign start_ok  = bus.start && (state == S_IDLE);
   assign start_run = start_ok && (bus.len_kij != 4'd0) && (bus.len_nij != '0);
   assign rd_issue  = (state == S_O_DRAIN) && bus.ofifo_valid && !rd_all;
   assign wr_last   = (state == S_O_DRAIN) && wr_pend_q && wr_tc;
   assign more_kij  = ({1'b0, kij_q} + 5'd1) < {1'b0, len_kij_q};

   // Phase length selection: the phase ends when ph_cnt reaches ph_term.
   always_comb begin
      ph_term = '0;
      case (state)
         S_W_FILL:  ph_term = cnt_w'(col);
         S_W_LOAD:  ph_term = cnt_w'(col - 1);
         S_W_DRAIN: ph_term = cnt_w'(row + col - 1);
         S_A_FILL:  ph_term = len_nij_q;
         S_EXEC:    ph_term = len_nij_q - 1'b1;
         default:   ph_term = '0;
      endcase
   end

   seq_counter #(.W(cnt_w)) u_ph_cnt (
      .clk(clk), .reset(reset),
      .load(state_next != state), .load_val('0), .en(state != S_IDLE),
      .term(ph_term), .count(ph_cnt), .tc(ph_tc)
   );

   seq_counter #(.W(cnt_w)) u_rd_cnt (
      .clk(clk), .reset(reset),
      .load(state != S_O_DRAIN), .load_val('0), .en(rd_issue),
      .term(len_nij_q), .count(rd_cnt), .tc(rd_all)
   );

   seq_counter #(.W(cnt_w)) u_wr_cnt (
      .clk(clk), .reset(reset),
      .load(state != S_O_DRAIN), .load_val('0), .en(wr_pend_q),
      .term(len_nij_q - 1'b1), .count(wr_cnt), .tc(wr_tc)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic and the instruction/status word for this cycle.
   always_comb begin
      state_next = state;
      inst_d     = IDLE_INST;
      busy_d     = (state != S_IDLE) && (state != S_DONE);
      done_d     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_run) begin
               state_next = S_W_FILL;
               busy_d     = 1'b1;
            end
            // Zero-length layer: report completion without touching SRAM.
            done_d = start_ok && !start_run;
         end
         S_W_FILL: begin
            if (ph_cnt < cnt_w'(col)) begin
               inst_d[BIT_CEN_X] = 1'b0;
               inst_d[A_X_LSB +: addr_w] = w_base_q + w_off_q + addr_w'(ph_cnt);
            end
            inst_d[BIT_L0_WR] = (ph_cnt != '0);
            if (ph_tc) state_next = S_W_LOAD;
         end
         S_W_LOAD: begin
            inst_d[BIT_L0_RD] = 1'b1;
            inst_d[BIT_LOAD]  = 1'b1;
            if (ph_tc) state_next = S_W_DRAIN;
         end
         S_W_DRAIN: begin
            if (ph_tc) state_next = S_A_FILL;
         end
         S_A_FILL: begin
            if (ph_cnt < len_nij_q) begin
               inst_d[BIT_CEN_X] = 1'b0;
               inst_d[A_X_LSB +: addr_w] = x_base_q + addr_w'(ph_cnt);
            end
            inst_d[BIT_L0_WR] = (ph_cnt != '0);
            if (ph_tc) state_next = S_EXEC;
         end
         S_EXEC: begin
            inst_d[BIT_L0_RD] = 1'b1;
            inst_d[BIT_EXEC]  = 1'b1;
            if (ph_tc) state_next = S_O_DRAIN;
         end
         S_O_DRAIN: begin
            inst_d[BIT_OFIFO_RD] = rd_issue;
            if (wr_pend_q) begin
               inst_d[BIT_CEN_P] = 1'b0;
               inst_d[BIT_WEN_P] = 1'b0;
               inst_d[A_P_LSB +: addr_w] = p_base_q + p_off_q + addr_w'(wr_cnt);
            end
            if (wr_last) state_next = more_kij ? S_W_FILL : S_DONE;
         end
         S_DONE: begin
            done_d     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Registered outputs, captured configuration and per-kij offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_q    <= IDLE_INST;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_pend_q <= 1'b0;
         len_kij_q <= '0;
         len_nij_q <= '0;
         w_base_q  <= '0;
         x_base_q  <= '0;
         p_base_q  <= '0;
         kij_q     <= '0;
         w_off_q   <= '0;
         p_off_q   <= '0;
      end else begin
         inst_q    <= inst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_pend_q <= rd_issue;
         if (start_run) begin
            len_kij_q <= bus.len_kij;
            len_nij_q <= bus.len_nij;
            w_base_q  <= bus.w_base;
            x_base_q  <= bus.x_base;
            p_base_q  <= bus.p_base;
            kij_q     <= '0;
            w_off_q   <= '0;
            p_off_q   <= '0;
         end else if (wr_last && more_kij) begin
            kij_q   <= kij_q + 4'd1;
            w_off_q <= w_off_q + addr_w'(col);
            p_off_q <= p_off_q + addr_w'(len_nij_q);
         end
      end
   end

   assign bus.inst      = inst_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.kij_idx   = kij_q;
   assign bus.state_dbg = state;

endmodule
